// File: rtl/frogger_ctrl_pkg.sv
// Shared definitions for the frogger direction controls.
//   DIR_*      : 2-bit move direction codes
//   state_e    : button repeat FSM state encoding
//   prio_enc() : 4-bit button vector -> direction, up > down > left > right
package frogger_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Lowest set bit wins. An all-zero vector returns DIR_RIGHT, so callers
  // gate the result with |v.
  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    if (v[0])      return DIR_UP;
    else if (v[1]) return DIR_DOWN;
    else if (v[2]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/move_event_buffer.sv
// Single-entry valid/ready holding register for move commands.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   emit, emit_dir : new command from the repeat FSM (one-cycle strobe)
//   ready          : consumer takes the pending command this cycle
//   valid, dir     : pending command
//   overrun        : one-cycle pulse when an unaccepted command is replaced
module move_event_buffer
  import frogger_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       emit,
  input  logic [1:0] emit_dir,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] dir,
  output logic       overrun
);

  logic       valid_q, valid_d;
  logic [1:0] dir_q, dir_d;
  logic       ovr_q, ovr_d;

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    ovr_d   = 1'b0;
    if (emit) begin
      // Latest command wins; flag it only if the old one was never taken.
      valid_d = 1'b1;
      dir_d   = emit_dir;
      ovr_d   = valid_q & ~ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      dir_q   <= DIR_UP;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid   = valid_q;
  assign dir     = dir_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/button_repeat_ctrl.sv
// Turns debounced direction-button levels into discrete move commands:
// one move per new press, auto-repeat after INIT_DELAY, then every
// REPEAT_PERIOD cycles while held.
//   BR_CLOCK_50   : clock, all logic on rising edge
//   BR_Reset      : synchronous active-high reset
//   BR_Enable     : 0 holds the FSM idle (pending command survives)
//   BR_Buttons_In : {right, left, down, up}, active high
//   BR_Move_Ready : consumer accepts the pending command
//   BR_Move_Valid : command pending
//   BR_Move_Dir   : 0 up, 1 down, 2 left, 3 right
//   BR_Overrun    : pulse when an unaccepted command is overwritten
//   BR_Held       : FSM is in HOLD or REPEAT
module button_repeat_ctrl
  import frogger_ctrl_pkg::*;
#(
  parameter int INIT_DELAY    = 20000000,
  parameter int REPEAT_PERIOD = 7500000,
  parameter int CNT_W         = 25
) (
  input  logic       BR_CLOCK_50,
  input  logic       BR_Reset,
  input  logic       BR_Enable,
  input  logic [3:0] BR_Buttons_In,
  input  logic       BR_Move_Ready,
  output logic       BR_Move_Valid,
  output logic [1:0] BR_Move_Dir,
  output logic       BR_Overrun,
  output logic       BR_Held
);

  localparam logic [CNT_W-1:0] INIT_TC = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_PERIOD - 1);

  logic [3:0]       btn_q, btn_q2;
  state_e           state_q;
  logic [1:0]       sel_dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             emit_q;
  logic [1:0]       emit_dir_q;
  logic             held_q;

  logic [3:0]       rise;
  logic [1:0]       rise_dir;
  logic [CNT_W-1:0] term;

  assign rise     = btn_q & ~btn_q2;
  assign rise_dir = prio_enc(rise);
  assign term     = (state_q == ST_HOLD) ? INIT_TC : REP_TC;

  always_ff @(posedge BR_CLOCK_50) begin
    if (BR_Reset) begin
      // Prime both history stages with the current level so a button held
      // through reset shows no edge and does not fire on release of reset.
      btn_q      <= BR_Buttons_In;
      btn_q2     <= BR_Buttons_In;
      state_q    <= ST_IDLE;
      sel_dir_q  <= DIR_UP;
      cnt_q      <= '0;
      emit_q     <= 1'b0;
      emit_dir_q <= DIR_UP;
      held_q     <= 1'b0;
    end else begin
      // History keeps sampling while disabled so a held button does not
      // look like a fresh press on re-enable.
      btn_q  <= BR_Buttons_In;
      btn_q2 <= btn_q;
      emit_q <= 1'b0;
      if (!BR_Enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        held_q  <= 1'b0;
      end else if (|rise) begin
        // A fresh press always wins, from any state and even on release.
        emit_q     <= 1'b1;
        emit_dir_q <= rise_dir;
        sel_dir_q  <= rise_dir;
        cnt_q      <= '0;
        state_q    <= ST_HOLD;
        held_q     <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_HOLD, ST_REPEAT: begin
            if (!btn_q[sel_dir_q]) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              held_q  <= 1'b0;
            end else if (cnt_q == term) begin
              emit_q     <= 1'b1;
              emit_dir_q <= sel_dir_q;
              cnt_q      <= '0;
              state_q    <= ST_REPEAT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  move_event_buffer u_buf (
    .clock    (BR_CLOCK_50),
    .reset    (BR_Reset),
    .emit     (emit_q),
    .emit_dir (emit_dir_q),
    .ready    (BR_Move_Ready),
    .valid    (BR_Move_Valid),
    .dir      (BR_Move_Dir),
    .overrun  (BR_Overrun)
  );

  assign BR_Held = held_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
module tb_button_repeat_ctrl;

  localparam int INIT = 8;
  localparam int PER  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] btn = 4'h0;
  logic       rdy = 1'b1;
  logic       mv;
  logic [1:0] md;
  logic       ovr;
  logic       held;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  button_repeat_ctrl #(.INIT_DELAY(INIT), .REPEAT_PERIOD(PER), .CNT_W(4)) dut (
    .BR_CLOCK_50   (clk),
    .BR_Reset      (rst),
    .BR_Enable     (en),
    .BR_Buttons_In (btn),
    .BR_Move_Ready (rdy),
    .BR_Move_Valid (mv),
    .BR_Move_Dir   (md),
    .BR_Overrun    (ovr),
    .BR_Held       (held)
  );

  // Reference model: tracks the held direction and the number of cycles
  // since the last move against the interval required for the next one.
  logic [3:0] m_b1 = 0, m_b2 = 0;
  logic       m_mode = 0;
  logic [1:0] m_sel = 0;
  int         m_since = 0, m_need = INIT;
  logic       m_pe = 0;
  logic [1:0] m_pd = 0;
  logic       m_v = 0, m_o = 0;
  logic [1:0] m_d = 0;

  function automatic logic [1:0] first_dir(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_update(input logic [3:0] b, input logic r, input logic e, input logic rs);
    logic [3:0] rise;
    if (rs) begin
      m_b1 = b; m_b2 = b; m_mode = 0; m_sel = 0; m_since = 0; m_need = INIT;
      m_pe = 0; m_pd = 0; m_v = 0; m_d = 0; m_o = 0;
      return;
    end
    m_o = m_pe && m_v && !r;
    if (m_pe) begin m_v = 1; m_d = m_pd; end
    else if (m_v && r) m_v = 0;
    rise = m_b1 & ~m_b2;
    m_pe = 0;
    if (!e) m_mode = 0;
    else if (rise != 0) begin
      m_pe = 1; m_pd = first_dir(rise); m_sel = m_pd;
      m_mode = 1; m_since = 0; m_need = INIT;
    end else if (m_mode && !m_b1[m_sel]) m_mode = 0;
    else if (m_mode) begin
      m_since++;
      if (m_since == m_need) begin
        m_pe = 1; m_pd = m_sel; m_since = 0; m_need = PER;
      end
    end
    m_b2 = m_b1; m_b1 = b;
  endtask

  task automatic step(input logic [3:0] b, input logic r, input logic e, input logic rs);
    btn = b; rdy = r; en = e; rst = rs;
    @(posedge clk);
    model_update(b, r, e, rs);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input logic [1:0] ed,
                     input logic eo, input logic eh);
    nvec++;
    if (mv !== ev || (ev && md !== ed) || ovr !== eo || held !== eh) begin
      nerr++;
      $display("FAIL %s: got v=%b d=%0d o=%b h=%b, want v=%b d=%0d o=%b h=%b",
               name, mv, md, ovr, held, ev, ed, eo, eh);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, m_v, m_d, m_o, m_mode);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] btn;
    logic       rdy;
    logic       ev;
    logic [1:0] ed;
    logic       eo;
    logic       eh;
  } vec_t;

  vec_t tbl[15];
  int   pos[$];
  int   dirs[$];
  int   exp_pos[7];
  int   cnt;

  initial begin
    // Tap of up (rows 1-3), then backpressure with a left press on top.
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].btn, tbl[i].rdy, tbl[i].en, tbl[i].rst);
      chk($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].eh);
    end

    // Hold right 30 cycles: moves at 0,8,12,...,28 relative to the first.
    exp_pos = '{0, 8, 12, 16, 20, 24, 28};
    pos.delete(); dirs.delete();
    for (int i = 0; i < 40; i++) begin
      step(i < 30 ? 4'h8 : 4'h0, 1'b1, 1'b1, 1'b0);
      chk_model("hold_model");
      if (mv) begin pos.push_back(i); dirs.push_back(int'(md)); end
    end
    chk_int("hold_count", pos.size(), 7);
    if (pos.size() == 7)
      for (int i = 0; i < 7; i++) begin
        chk_int($sformatf("hold_pos[%0d]", i), pos[i] - pos[0], exp_pos[i]);
        chk_int($sformatf("hold_dir[%0d]", i), dirs[i], 3);
      end

    // Down and left together: one move (down); releasing down leaves left silent.
    pos.delete(); dirs.delete();
    for (int i = 0; i < 15; i++) begin
      step(i < 6 ? 4'h6 : (i < 12 ? 4'h4 : 4'h0), 1'b1, 1'b1, 1'b0);
      chk_model("simul_model");
      if (mv) begin pos.push_back(i); dirs.push_back(int'(md)); end
      if (i == 11) chk("simul_released_idle", 1'b0, 2'd0, 1'b0, 1'b0);
    end
    chk_int("simul_count", pos.size(), 1);
    if (pos.size() == 1) chk_int("simul_dir", dirs[0], 1);

    // Left into REPEAT, then right rises: immediate right, next 8 later.
    pos.delete(); cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(i < 14 ? 4'h4 : (i < 26 ? 4'hC : 4'h0), 1'b1, 1'b1, 1'b0);
      chk_model("switch_model");
      if (mv && md == 2'd3) pos.push_back(i);
      if (mv && md != 2'd3 && pos.size() > 0) cnt++;
    end
    chk_int("switch_right_count", pos.size(), 2);
    if (pos.size() == 2) chk_int("switch_spacing", pos[1] - pos[0], INIT);
    chk_int("switch_no_left_after", cnt, 0);

    // Reset mid-repeat with up still held: nothing fires until re-press.
    for (int i = 0; i < 14; i++) begin
      step(4'h1, 1'b1, 1'b1, 1'b0);
      chk_model("rsthold_model");
    end
    step(4'h1, 1'b1, 1'b1, 1'b1);
    chk("rst_midhold", 1'b0, 2'd0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'h1, 1'b1, 1'b1, 1'b0);
      chk_model("rst_after_model");
      if (mv || held) cnt++;
    end
    chk_int("rst_no_refire", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(i < 3 ? 4'h0 : 4'h1, 1'b1, 1'b1, 1'b0);
      chk_model("repress_model");
      if (mv) cnt++;
    end
    chk_int("repress_count", cnt, 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] b;
      b = btn;
      if ($urandom_range(0, 5) == 0) b[$urandom_range(0, 3)] ^= 1'b1;
      step(b, $urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0,
           $urandom_range(0, 200) == 0);
      chk_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
